// File: rtl/pong_ball_controller.sv
// Pong rules engine: serve timing, collision detection, bounce handshake
// with the ball component, scoring and game-over handling.
module pong_ball_controller #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_W      = 15,
    parameter int BALL_H      = 15,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 60,
    parameter int LPAD_X      = 20,
    parameter int RPAD_X      = 610,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic       tick,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] ball_posx,
    input  logic [9:0] ball_posy,
    input  logic [9:0] lpad_y,
    input  logic [9:0] rpad_y,
    output logic       bounce_trigger,
    output logic       bounce_direction,
    output logic       ball_run,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE, SERVE, PLAY, BOUNCE, SCORED, OVER
    } state_t;

    localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);

    localparam logic [10:0] SW  = 11'(SCREEN_W);
    localparam logic [10:0] SH  = 11'(SCREEN_H);
    localparam logic [10:0] BW  = 11'(BALL_W);
    localparam logic [10:0] BH  = 11'(BALL_H);
    localparam logic [10:0] PW  = 11'(PADDLE_W);
    localparam logic [10:0] PH  = 11'(PADDLE_H);
    localparam logic [10:0] LX  = 11'(LPAD_X);
    localparam logic [10:0] RX  = 11'(RPAD_X);
    localparam logic [3:0]  WIN = 4'(WIN_SCORE);

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic            armed;
    logic [9:0]      lat_x;
    logic [9:0]      lat_y;

    logic [10:0] px, py, ly, ry;
    logic        miss_l, miss_r, hit_l, hit_r, wall, moved;
    logic        inc_l, inc_r, clr, dir_n, run_n;

    // Collision terms, widened to 11 bits so the sums never wrap
    always_comb begin
        px     = {1'b0, ball_posx};
        py     = {1'b0, ball_posy};
        ly     = {1'b0, lpad_y};
        ry     = {1'b0, rpad_y};
        miss_l = (px == 11'd0);
        miss_r = (px + BW >= SW);
        hit_l  = (px <= LX + PW - 11'd1) && (px + BW > LX)
              && (py + BH > ly) && (py < ly + PH);
        hit_r  = (px + BW >= RX + 11'd1) && (px < RX + PW)
              && (py + BH > ry) && (py < ry + PH);
        wall   = (py == 11'd0) || (py + BH >= SH);
        moved  = (ball_posx != lat_x) || (ball_posy != lat_y);
    end

    // Next-state and scoring decisions
    always_comb begin
        nxt   = state;
        inc_l = 1'b0;
        inc_r = 1'b0;
        clr   = 1'b0;
        dir_n = bounce_direction;
        unique case (state)
            IDLE:   if (start) nxt = SERVE;
            SERVE:  if (cnt == SERVE_LAST) nxt = PLAY;
            PLAY: begin
                if (miss_l) begin
                    inc_r = 1'b1;
                    nxt   = SCORED;
                end else if (miss_r) begin
                    inc_l = 1'b1;
                    nxt   = SCORED;
                end else if (hit_l || hit_r) begin
                    dir_n = 1'b1;
                    nxt   = BOUNCE;
                end else if (wall) begin
                    dir_n = 1'b0;
                    nxt   = BOUNCE;
                end
            end
            BOUNCE: if (moved) nxt = PLAY;
            SCORED: begin
                if (score_l == WIN || score_r == WIN) nxt = OVER;
                else nxt = SERVE;
            end
            OVER: begin
                if (start) begin
                    clr = 1'b1;
                    nxt = SERVE;
                end
            end
            default: nxt = IDLE;
        endcase
        // Ball only runs once it has spent a full tick in play
        run_n = (state == PLAY || state == BOUNCE)
             && (nxt == PLAY || nxt == BOUNCE);
    end

    // State, counters, latches and registered outputs
    always_ff @(posedge tick or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            armed            <= 1'b0;
            lat_x            <= '0;
            lat_y            <= '0;
            bounce_trigger   <= 1'b0;
            bounce_direction <= 1'b0;
            ball_run         <= 1'b0;
            score_l          <= '0;
            score_r          <= '0;
            game_over        <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            state <= nxt;
            if (state == SERVE && nxt == SERVE) cnt <= cnt + 1'b1;
            else cnt <= '0;
            if (state == PLAY && nxt == BOUNCE) begin
                lat_x <= ball_posx;
                lat_y <= ball_posy;
            end
            bounce_direction <= dir_n;
            bounce_trigger   <= (nxt == BOUNCE);
            ball_run         <= run_n;
            game_over        <= (nxt == OVER);
            if (clr) begin
                score_l <= '0;
                score_r <= '0;
            end else begin
                if (inc_l && score_l != WIN) score_l <= score_l + 4'd1;
                if (inc_r && score_r != WIN) score_r <= score_r + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pong_ball_controller.sv
// Self-checking bench for pong_ball_controller: directed scenarios plus
// randomized play against a rule-level reference model.
module tb_pong_ball_controller;

    localparam int SW = 640, SH = 480, BW = 15, BH = 15;
    localparam int PW = 10, PH = 60, LX = 20, RX = 610;
    localparam int ST = 60, WIN = 9;

    logic       tick;
    logic       reset;
    logic       start;
    logic [9:0] px, py, ly, ry;
    logic       trig, dir, run, over;
    logic [3:0] sl, sr;

    pong_ball_controller dut (
        .tick(tick), .reset(reset), .start(start),
        .ball_posx(px), .ball_posy(py),
        .lpad_y(ly), .rpad_y(ry),
        .bounce_trigger(trig), .bounce_direction(dir),
        .ball_run(run), .score_l(sl), .score_r(sr),
        .game_over(over)
    );

    initial tick = 1'b0;
    always #5 tick = ~tick;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model: game phases described by the rules, not the RTL
    typedef enum int {M_WAIT, M_HOLD, M_LIVE, M_HIT, M_POINT, M_END} mode_t;
    mode_t m_mode;
    bit    m_armed;
    int    hold_cnt, lat_x, lat_y;
    int    e_sl, e_sr;
    bit    e_run, e_trig, e_dir, e_over;

    // 0 none, 1 miss left, 2 miss right, 3 paddle, 4 wall
    function automatic int classify(int x, int y, int l, int r);
        if (x == 0) return 1;
        if (x + BW >= SW) return 2;
        if (x <= LX + PW - 1 && x + BW > LX && y + BH > l && y < l + PH)
            return 3;
        if (x + BW >= RX + 1 && x < RX + PW && y + BH > r && y < r + PH)
            return 3;
        if (y == 0 || y + BH >= SH) return 4;
        return 0;
    endfunction

    function automatic bit live(mode_t m);
        return m == M_LIVE || m == M_HIT;
    endfunction

    task automatic model_reset();
        m_mode = M_WAIT; m_armed = 0; hold_cnt = 0;
        lat_x = 0; lat_y = 0; e_sl = 0; e_sr = 0;
        e_run = 0; e_trig = 0; e_dir = 0; e_over = 0;
    endtask

    task automatic model_edge();
        mode_t pm;
        int ev;
        if (!m_armed) begin
            m_armed = 1;
            return;
        end
        pm = m_mode;
        case (m_mode)
            M_WAIT: if (start) begin m_mode = M_HOLD; hold_cnt = 0; end
            M_HOLD: begin
                if (hold_cnt == ST - 1) m_mode = M_LIVE;
                else hold_cnt++;
            end
            M_LIVE: begin
                ev = classify(int'(px), int'(py), int'(ly), int'(ry));
                if (ev == 1) begin
                    if (e_sr < WIN) e_sr++;
                    m_mode = M_POINT;
                end else if (ev == 2) begin
                    if (e_sl < WIN) e_sl++;
                    m_mode = M_POINT;
                end else if (ev >= 3) begin
                    e_dir = (ev == 3);
                    lat_x = int'(px); lat_y = int'(py);
                    m_mode = M_HIT;
                end
            end
            M_HIT: if (int'(px) != lat_x || int'(py) != lat_y) m_mode = M_LIVE;
            M_POINT: begin
                if (e_sl == WIN || e_sr == WIN) m_mode = M_END;
                else begin m_mode = M_HOLD; hold_cnt = 0; end
            end
            M_END: begin
                if (start) begin
                    e_sl = 0; e_sr = 0;
                    m_mode = M_HOLD; hold_cnt = 0;
                end
            end
            default: m_mode = M_WAIT;
        endcase
        e_run  = live(pm) && live(m_mode);
        e_trig = (m_mode == M_HIT);
        e_over = (m_mode == M_END);
    endtask

    function automatic logic [15:0] dut_vec();
        return {4'd0, run, trig, dir, over, sl, sr};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {4'd0, e_run, e_trig, e_dir, e_over, 4'(e_sl), 4'(e_sr)};
    endfunction

    task automatic step();
        @(posedge tick);
        model_edge();
        #1;
        chk("outputs", dut_vec(), exp_vec());
    endtask

    // Asynchronous reset pulse between edges, released mid-cycle
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        chk("async_reset", dut_vec(), 16'd0);
        @(negedge tick);
        reset = 1'b1;
    endtask

    task automatic safe_pos();
        px = 10'd300; py = 10'd200; ly = 10'd200; ry = 10'd200;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        safe_pos();
        model_reset();
        #1 chk("reset_state", dut_vec(), 16'd0);
        @(negedge tick);
        reset = 1'b1;
        step();

        // Serve timing: ball_run rises 61 ticks after start is sampled
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            step();
            chk("serve_run", 16'(run), 16'(k == 61));
            chk("serve_trig", 16'(trig), 16'd0);
        end

        // Top wall bounce, held while frozen, dropped on movement
        py = 10'd0;
        step();
        chk("wall_trig", {trig, dir}, 16'b10);
        repeat (10) step();
        chk("wall_hold", 16'(trig), 16'd1);
        py = 10'd1;
        step();
        chk("wall_drop", 16'(trig), 16'd0);
        safe_pos();
        step();

        // Left paddle bounce, then left miss
        px = 10'd29; py = 10'd100; ly = 10'd80;
        step();
        chk("lpad_bounce", {trig, dir}, 16'b11);
        safe_pos();
        step();
        px = 10'd0;
        step();
        chk("miss_l_score", {sl, sr}, 16'h01);
        chk("miss_l_run", 16'(run), 16'd0);
        px = 10'd300;
        repeat (61) step();
        chk("reserve_low", 16'(run), 16'd0);
        step();
        chk("reserve_high", 16'(run), 16'd1);

        // Corner: paddle first, then wall after the move
        px = 10'd29; py = 10'd0; ly = 10'd0;
        step();
        chk("corner_pad", {trig, dir}, 16'b11);
        px = 10'd30;
        step();
        chk("corner_mid", 16'(trig), 16'd0);
        step();
        chk("corner_wall", {trig, dir}, 16'b10);
        safe_pos();
        step();
        step();

        // Right misses until the game ends
        for (int i = 0; i < 8; i++) begin
            px = 10'd625;
            step();
            safe_pos();
            repeat (62) step();
        end
        chk("score_l_8", 16'(sl), 16'd8);
        px = 10'd625;
        step();
        chk("score_l_9", {sl, sr}, 16'h91);
        step();
        chk("game_over", 16'(over), 16'd1);
        repeat (3) step();
        px = 10'd0;
        repeat (3) step();
        chk("score_sat", {over, sl, sr}, 16'h191);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("new_game", {over, sl, sr}, 16'h000);

        // Reset while a bounce is pending
        safe_pos();
        repeat (62) step();
        px = 10'd0;
        step();
        safe_pos();
        repeat (62) step();
        py = 10'd0;
        step();
        chk("pre_rst_trig", 16'(trig), 16'd1);
        do_reset();
        safe_pos();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (60) step();
        chk("post_rst_low", 16'(run), 16'd0);
        step();
        chk("post_rst_high", 16'(run), 16'd1);

        // Randomized play against the model
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 5))
                    0: px = 10'd0;
                    1: px = 10'($urandom_range(600, 640));
                    2: px = 10'($urandom_range(5, 40));
                    3: px = 10'($urandom_range(590, 625));
                    default: px = 10'($urandom_range(0, 1023));
                endcase
                case ($urandom_range(0, 3))
                    0: py = 10'd0;
                    1: py = 10'($urandom_range(455, 1023));
                    default: py = 10'($urandom_range(0, 479));
                endcase
                if ($urandom_range(0, 3) == 0) begin
                    ly = 10'($urandom_range(0, 1023));
                    ry = 10'($urandom_range(0, 1023));
                end
            end
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
